// File: rtl/hdmi_vid_pkg.sv
// Shared types and constants for the HDMI pixel output stage.
// FSM encoding, SOF marker position and colour-bar palette.
package hdmi_vid_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int SOF_BIT = 24;
  localparam int RGB_W   = 24;
  localparam int N_BARS  = 8;

  localparam logic [RGB_W-1:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] BAR_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] BAR_BLACK   = 24'h000000;

  function automatic logic [RGB_W-1:0] bar_rgb(
    input logic [2:0] idx
  );
    logic [RGB_W-1:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hdmi_vid_timing.sv
// Free-running video timing: h/v counters and raw HS/VS/DE.
// Also flags line end, frame end and the first active pixel.
module hdmi_vid_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int SYNC_POL = 1,
  parameter int HW       = 12,
  parameter int VW       = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [HW-1:0] h_cnt_o,
  output logic          de_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          first_o,
  output logic          eol_o,
  output logic          eof_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic POL_INV = (SYNC_POL == 0);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          hs_raw, vs_raw;

  assign eol_o = (h_cnt_q == H_LAST);
  assign eof_o = eol_o && (v_cnt_q == V_LAST);

  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (eol_o) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign hs_raw = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
  assign vs_raw = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

  assign h_cnt_o = h_cnt_q;
  assign de_o    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_o    = hs_raw ^ POL_INV;
  assign vs_o    = vs_raw ^ POL_INV;
  assign first_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/hdmi_vid_out.sv
// HDMI pixel stage: SOF-aligned FIFO pop, registered RGB/HS/VS/DE.
// Define HDMI_COLORBAR_EN to show colour bars while not streaming.
module hdmi_vid_out
  import hdmi_vid_pkg::*;
#(
  parameter int          H_ACTIVE = 1280,
  parameter int          H_FP     = 110,
  parameter int          H_SYNC   = 40,
  parameter int          H_BP     = 220,
  parameter int          V_ACTIVE = 720,
  parameter int          V_FP     = 5,
  parameter int          V_SYNC   = 5,
  parameter int          V_BP     = 20,
  parameter int          SYNC_POL = 1,
  parameter logic [23:0] FILL_RGB = 24'h000000
) (
  input  logic        rd_clk,
  input  logic        rd_rst,
  input  logic        rd_vld,
  input  logic [31:0] rd_data,
  output logic        rd_en,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic        vid_de,
  output logic [23:0] vid_rgb,
  output logic        frame_start,
  output logic        uflow,
  output logic [15:0] uflow_cnt
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT + 1);
  localparam int VW    = $clog2(V_TOT + 1);

  localparam logic POL_INV = (SYNC_POL == 0);

  logic [HW-1:0]    h_cnt;
  logic             de, hs, vs;
  logic             first, eol, eof;
  logic             sof, err;
  logic [RGB_W-1:0] idle_px;
  logic             unused_ok;

  state_e           state_q, state_d;
  logic             hs_q, vs_q, de_q;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             fs_q, fs_d;
  logic             uflow_q, uflow_d;
  logic [15:0]      cnt_q, cnt_d;

  hdmi_vid_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk_i   (rd_clk),
    .rst_i   (rd_rst),
    .h_cnt_o (h_cnt),
    .de_o    (de),
    .hs_o    (hs),
    .vs_o    (vs),
    .first_o (first),
    .eol_o   (eol),
    .eof_o   (eof)
  );

  assign sof = rd_data[SOF_BIT];

`ifdef HDMI_COLORBAR_EN
  localparam int AW = $clog2(H_ACTIVE + 8) + 1;
  localparam logic [HW-1:0] H_ACT_M1 = HW'(H_ACTIVE - 1);

  // acc tracks h*8 mod H_ACTIVE so the bar index needs no divider
  logic [AW-1:0] acc_q, acc_d, acc_step;
  logic [2:0]    bar_q, bar_d;

  always_comb begin
    acc_d    = acc_q;
    bar_d    = bar_q;
    acc_step = acc_q + AW'(8);
    if (eol) begin
      acc_d = '0;
      bar_d = '0;
    end else if (h_cnt < H_ACT_M1) begin
      if (acc_step >= AW'(H_ACTIVE)) begin
        acc_d = acc_step - AW'(H_ACTIVE);
        bar_d = bar_q + 3'd1;
      end else begin
        acc_d = acc_step;
      end
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      acc_q <= '0;
      bar_q <= '0;
    end else begin
      acc_q <= acc_d;
      bar_q <= bar_d;
    end
  end

  assign idle_px   = bar_rgb(bar_q);
  assign unused_ok = ^rd_data[31:25];
`else
  assign idle_px   = FILL_RGB;
  assign unused_ok = ^{rd_data[31:25], h_cnt, eol};
`endif

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    err     = 1'b0;
    case (state_q)
      ST_WAIT: begin
        rd_en = rd_vld && !sof;
        if (rd_vld && sof) state_d = ST_ARMED;
      end
      // enter RUN as the counters wrap so RUN owns pixel (0,0)
      ST_ARMED: begin
        if (eof) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (de) begin
          if (!rd_vld || (sof != first)) begin
            err     = 1'b1;
            state_d = ST_WAIT;
          end else begin
            rd_en = 1'b1;
          end
        end
      end
      default: state_d = ST_WAIT;
    endcase
    if (rd_rst) rd_en = 1'b0;
  end

  always_comb begin
    rgb_d = '0;
    if (de) begin
      if (state_q != ST_RUN) rgb_d = idle_px;
      else if (err)          rgb_d = FILL_RGB;
      else                   rgb_d = rd_data[RGB_W-1:0];
    end
    fs_d    = first && (state_q == ST_RUN) && !err;
    uflow_d = uflow_q || err;
    cnt_d   = cnt_q;
    if (err && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q <= ST_WAIT;
      hs_q    <= POL_INV;
      vs_q    <= POL_INV;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
      uflow_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hs_q    <= hs;
      vs_q    <= vs;
      de_q    <= de;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
      uflow_q <= uflow_d;
      cnt_q   <= cnt_d;
    end
  end

  assign vid_hs      = hs_q;
  assign vid_vs      = vs_q;
  assign vid_de      = de_q;
  assign vid_rgb     = rgb_q;
  assign frame_start = fs_q;
  assign uflow       = uflow_q;
  assign uflow_cnt   = cnt_q;

endmodule

// File: tb/tb_hdmi_vid_out.sv
// Bench for hdmi_vid_out: scenario table, reset/colour-bar sequences
// and randomized FIFO traffic against a frame-level reference model.
module tb_hdmi_vid_out;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 2;
  localparam int HB = 2;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [23:0] FILL = 24'h102030;

  localparam logic [23:0] BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        rd_vld;
  logic [31:0] rd_data;
  logic        rd_en;
  logic        vid_hs, vid_vs, vid_de;
  logic [23:0] vid_rgb;
  logic        frame_start;
  logic        uflow;
  logic [15:0] uflow_cnt;

  always #5 rd_clk = ~rd_clk;

  hdmi_vid_out #(
    .H_ACTIVE (HA),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB),
    .SYNC_POL (1),
    .FILL_RGB (FILL)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .rd_vld      (rd_vld),
    .rd_data     (rd_data),
    .rd_en       (rd_en),
    .vid_hs      (vid_hs),
    .vid_vs      (vid_vs),
    .vid_de      (vid_de),
    .vid_rgb     (vid_rgb),
    .frame_start (frame_start),
    .uflow       (uflow),
    .uflow_cnt   (uflow_cnt)
  );

  typedef struct {
    string name;
    int    junk;
    int    frames;
    int    xsof;
    int    drop_px;
    int    run_fr;
    int    e_pops;
    int    e_uflow;
    int    e_cnt;
    int    e_fs;
  } vec_t;

  vec_t        tab [4];
  logic [23:0] bar_exp [8];

  int          n_chk = 0;
  int          n_pass = 0;
  int          t = 0;
  int          mode = 0;
  logic        m_uflow = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [31:0] q [$];
  int          drop_t = -1;
  int          gap_pct = 0;
  int          dut_pops = 0;
  int          dut_fs = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0d)", nm, act, exp, t);
  endtask

  function automatic logic [23:0] idle_px(input int h);
`ifdef HDMI_COLORBAR_EN
    return BARS[(h * 8) / HA];
`else
    return FILL;
`endif
  endfunction

  task automatic load(input int junk, input int frames, input int xsof);
    logic [31:0] w;
    for (int j = 0; j < junk; j++) begin
      w = $urandom;
      w[24] = 1'b0;
      q.push_back(w);
    end
    for (int f = 0; f < frames; f++) begin
      for (int k = 0; k < 32; k++) begin
        w = $urandom;
        w[24] = (k == 0) || (k == xsof);
        q.push_back(w);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    rd_rst  = 1'b1;
    rd_vld  = 1'b1;
    rd_data = 32'h0000_00AA;
    #1;
    chk("reset",
        {vid_de, vid_hs, vid_vs, vid_rgb, frame_start, uflow, uflow_cnt, rd_en},
        {1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 16'h0, 1'b0});
    @(negedge rd_clk);
    rd_rst   = 1'b0;
    t        = 0;
    mode     = 0;
    m_uflow  = 1'b0;
    m_cnt    = '0;
    dut_pops = 0;
    dut_fs   = 0;
  endtask

  // One pixel clock: model predicts pop and the outputs that follow it
  task automatic step();
    int          h, v;
    logic        de, first, last, vld, pop, err, fs, e_hs, e_vs;
    logic [31:0] dat;
    logic [23:0] px;
    vld = q.size() > 0;
    if (t == drop_t) vld = 1'b0;
    if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) vld = 1'b0;
    dat = (q.size() > 0) ? q[0] : 32'hDEAD_BEEF;
    rd_vld  = vld;
    rd_data = dat;
    #1;
    h     = t % HT;
    v     = (t / HT) % VT;
    de    = (h < HA) && (v < VA);
    first = (t % FT) == 0;
    last  = (t % FT) == FT - 1;
    pop   = 1'b0;
    err   = 1'b0;
    fs    = 1'b0;
    px    = de ? idle_px(h) : 24'h0;
    case (mode)
      0: begin
        if (vld && dat[24]) mode = 1;
        else if (vld) pop = 1'b1;
      end
      1: if (last) mode = 2;
      default: begin
        if (de) begin
          if (!vld || (dat[24] != first)) begin
            err = 1'b1;
            px  = FILL;
          end else begin
            pop = 1'b1;
            px  = dat[23:0];
            fs  = first;
          end
        end
      end
    endcase
    if (err) begin
      mode    = 0;
      m_uflow = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt++;
    end
    e_hs = (h >= HA + HF) && (h < HA + HF + HS);
    e_vs = (v >= VA + VF) && (v < VA + VF + VS);
    chk("rd_en", rd_en, pop);
    dut_pops += int'(rd_en);
    @(negedge rd_clk);
    if (pop) void'(q.pop_front());
    chk("video", {vid_de, vid_hs, vid_vs, vid_rgb, frame_start},
        {de, e_hs, e_vs, px, fs});
    chk("uflow", {uflow, uflow_cnt}, {m_uflow, m_cnt});
    dut_fs += int'(frame_start);
    t++;
  endtask

  initial begin
    rd_rst  = 1'b1;
    rd_vld  = 1'b0;
    rd_data = '0;

    tab[0] = '{"basic",    0, 1, -1, -1, 2, 32, 0, 0, 1};
    tab[1] = '{"junk3",    3, 1, -1, -1, 2, 35, 0, 0, 1};
    tab[2] = '{"underrun", 0, 2, -1, 13, 3, 64, 1, 1, 2};
    tab[3] = '{"sof_mid",  0, 1,  5, -1, 2,  5, 1, 1, 1};

    for (int i = 0; i < 4; i++) begin
      q.delete();
      load(tab[i].junk, tab[i].frames, tab[i].xsof);
      gap_pct = 0;
      drop_t  = (tab[i].drop_px < 0) ? -1 :
                FT + (tab[i].drop_px / HA) * HT + (tab[i].drop_px % HA);
      do_reset();
      repeat (tab[i].run_fr * FT) step();
      chk({tab[i].name, "_pops"}, dut_pops, tab[i].e_pops);
      chk({tab[i].name, "_uflow"}, uflow, tab[i].e_uflow);
      chk({tab[i].name, "_cnt"}, uflow_cnt, tab[i].e_cnt);
      chk({tab[i].name, "_fs"}, dut_fs, tab[i].e_fs);
    end

    // reset mid-line after an error; FIFO contents survive
    drop_t = -1;
    q.delete();
    load(0, 2, 5);
    do_reset();
    repeat (FT + 20) step();
    chk("pre_rst_uflow", uflow, 1'b1);
    do_reset();
    repeat (2 * FT) step();

    // empty FIFO: idle pixels on the first line
    q.delete();
    for (int h = 0; h < 8; h++) begin
`ifdef HDMI_COLORBAR_EN
      bar_exp[h] = BARS[h];
`else
      bar_exp[h] = FILL;
`endif
    end
    do_reset();
    for (int h = 0; h < 8; h++) begin
      step();
      chk($sformatf("idle_px%0d", h), vid_rgb, bar_exp[h]);
    end

    for (int r = 0; r < 4; r++) begin
      q.delete();
      load($urandom_range(0, 4), 4, (r == 3) ? $urandom_range(1, 31) : -1);
      gap_pct = r * 2;
      drop_t  = -1;
      do_reset();
      repeat (5 * FT) step();
      chk("rand_cnt", uflow_cnt, m_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
